// File: rtl/de_reg_pkg.sv
// de_reg_pkg: shared pipeline constants for the decode/execute register stages
package de_reg_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int RFWDMUX_W = 3;
  localparam int ALUBMUX_W = 3;
  localparam int ALUOP_W = 4;
  localparam int DMOP_W = 3;
  localparam int DTRF_W = 2;
  localparam int TNEW_W = 3;
  localparam logic [XLEN-1:0] PC_RST = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic [RFWDMUX_W-1:0] rfwdmux;
    logic [ALUBMUX_W-1:0] alubmux;
    logic [ALUOP_W-1:0] aluop;
    logic [DMOP_W-1:0] dmop;
    logic [DTRF_W-1:0] dtrfsel;
    logic [TNEW_W-1:0] tnew;
  } ctrl_t;
endpackage

// File: rtl/de_reg_if.sv
// de_reg_if: decode-stage inputs and execute-stage outputs of the D/E register
interface de_reg_if;
  import de_reg_pkg::*;
  logic [XLEN-1:0] InstrD, PCD, RD1D, RD2D, ExtD;
  logic [REG_W-1:0] A3D;
  logic RFWED, DmweD;
  logic [RFWDMUX_W-1:0] RFWDMUXD;
  logic [ALUBMUX_W-1:0] ALUBMUXD;
  logic [ALUOP_W-1:0] ALUOPD;
  logic [DMOP_W-1:0] DMOPD;
  logic [DTRF_W-1:0] DATATORFSELD;
  logic [TNEW_W-1:0] TnewD;
  logic [XLEN-1:0] InstrE, PCE, RD1E, RD2E, ExtE;
  logic [REG_W-1:0] A3E;
  logic RFWEE, DmweE;
  logic [RFWDMUX_W-1:0] RFWDMUXE;
  logic [ALUBMUX_W-1:0] ALUBMUXE;
  logic [ALUOP_W-1:0] ALUOPE;
  logic [DMOP_W-1:0] DMOPE;
  logic [DTRF_W-1:0] DATATORFSELE;
  logic [TNEW_W-1:0] TnewE;
  logic ValidE;
  logic [XLEN-1:0] BubbleCnt;
  modport master (
    output InstrD, PCD, RD1D, RD2D, ExtD, A3D, RFWED, DmweD,
           RFWDMUXD, ALUBMUXD, ALUOPD, DMOPD, DATATORFSELD, TnewD,
    input  InstrE, PCE, RD1E, RD2E, ExtE, A3E, RFWEE, DmweE,
           RFWDMUXE, ALUBMUXE, ALUOPE, DMOPE, DATATORFSELE, TnewE, ValidE, BubbleCnt
  );
  modport slave (
    input  InstrD, PCD, RD1D, RD2D, ExtD, A3D, RFWED, DmweD,
           RFWDMUXD, ALUBMUXD, ALUOPD, DMOPD, DATATORFSELD, TnewD,
    output InstrE, PCE, RD1E, RD2E, ExtE, A3E, RFWEE, DmweE,
           RFWDMUXE, ALUBMUXE, ALUOPE, DMOPE, DATATORFSELE, TnewE, ValidE, BubbleCnt
  );
endinterface

// File: rtl/de_reg_pipe_field.sv
// pipe_field: pipeline field register with sync active-low reset, enable and clear
module pipe_field #(
  parameter int W = 1,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= !reset ? RV : en ? (clr ? '0 : d) : q;
endmodule

// File: rtl/de_reg.sv
// de_reg: decode/execute pipeline register with hold, bubble insertion and bubble counter
module de_reg
  import de_reg_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic stall,
  input logic flush,
  input logic hold_e,
  de_reg_if.slave bus
);
  logic en, bubble;
  logic [REG_W-1:0] a3_d;
  ctrl_t ctrl_d, ctrl_e;
  logic [XLEN-1:0] bubble_cnt;
  assign en = !hold_e;
  assign bubble = stall | flush;
  // a non-writing instruction must never look like a forwarding source
  assign a3_d = bus.RFWED ? bus.A3D : '0;
  assign ctrl_d = {bus.RFWDMUXD, bus.ALUBMUXD, bus.ALUOPD, bus.DMOPD, bus.DATATORFSELD, bus.TnewD};
  assign {bus.RFWDMUXE, bus.ALUBMUXE, bus.ALUOPE, bus.DMOPE, bus.DATATORFSELE, bus.TnewE} = ctrl_e;
  assign bus.BubbleCnt = bubble_cnt;
  pipe_field #(.W(XLEN), .RV(NOP)) u_instr (.clk, .reset, .en, .clr(bubble), .d(bus.InstrD), .q(bus.InstrE));
  pipe_field #(.W(XLEN), .RV(PC_RST)) u_pc (.clk, .reset, .en, .clr(1'b0), .d(bus.PCD), .q(bus.PCE));
  pipe_field #(.W(XLEN)) u_rd1 (.clk, .reset, .en, .clr(bubble), .d(bus.RD1D), .q(bus.RD1E));
  pipe_field #(.W(XLEN)) u_rd2 (.clk, .reset, .en, .clr(bubble), .d(bus.RD2D), .q(bus.RD2E));
  pipe_field #(.W(XLEN)) u_ext (.clk, .reset, .en, .clr(bubble), .d(bus.ExtD), .q(bus.ExtE));
  pipe_field #(.W(REG_W)) u_a3 (.clk, .reset, .en, .clr(bubble), .d(a3_d), .q(bus.A3E));
  pipe_field #(.W(1)) u_rfwe (.clk, .reset, .en, .clr(bubble), .d(bus.RFWED), .q(bus.RFWEE));
  pipe_field #(.W(1)) u_dmwe (.clk, .reset, .en, .clr(bubble), .d(bus.DmweD), .q(bus.DmweE));
  pipe_field #(.W($bits(ctrl_t))) u_ctrl (.clk, .reset, .en, .clr(bubble), .d(ctrl_d), .q(ctrl_e));
  pipe_field #(.W(1)) u_valid (.clk, .reset, .en, .clr(bubble), .d(1'b1), .q(bus.ValidE));
  always_ff @(posedge clk)
    if (!reset) bubble_cnt <= '0;
    else if (en && bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
endmodule

// File: doc/de_reg.md
DE_REG -- requirements
Module: de_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on the rising clk edge).
REQ-003 SHALL have port stall, input, 1 bit: the hazard unit stalls D; insert a bubble into E.
REQ-004 SHALL have port flush, input, 1 bit: squash the D instruction; insert a bubble into E.
REQ-005 SHALL have port hold_e, input, 1 bit: freeze the E register for multi-cycle E operations.
REQ-006 SHALL have ports InstrD, PCD, RD1D, RD2D, ExtD, input, 32 bits each: D-stage data.
REQ-007 SHALL have port A3D, input, 5 bits: decoded destination register.
REQ-008 SHALL have ports RFWED and DmweD, input, 1 bit each: decoded write enables.
REQ-009 SHALL have ports RFWDMUXD (3), ALUBMUXD (3), ALUOPD (4), DMOPD (3), DATATORFSELD (2) and TnewD (3), input: decoded controls, widths in bits as given.
REQ-010 SHALL have outputs InstrE, PCE, RD1E, RD2E, ExtE, A3E, RFWEE, DmweE, RFWDMUXE, ALUBMUXE, ALUOPE, DMOPE, DATATORFSELE and TnewE, each the same width as its D counterpart.
REQ-011 SHALL have port ValidE, output, 1 bit: 1 = E holds a real instruction, 0 = bubble.
REQ-012 SHALL have port BubbleCnt, output, 32 bits: count of bubbles inserted.

Function
REQ-013 SHALL apply per-edge priority: reset > hold_e > (stall | flush) > capture.
REQ-014 SHALL, on capture, load every E register from its D input and set ValidE=1, with 1-cycle latency (D value visible on E outputs the cycle after the edge).
REQ-015 SHALL, when hold_e=1 (reset inactive), keep all E registers, ValidE and BubbleCnt unchanged, regardless of stall or flush.
REQ-016 SHALL, on bubble (stall|flush, hold_e=0): load InstrE=0 (nop), A3E=0, RFWEE=0, DmweE=0, all mux/op fields=0, TnewE=0, ValidE=0, and load PCE from PCD.
REQ-017 SHALL treat stall=1 and flush=1 together as a single bubble.
REQ-018 SHALL increment BubbleCnt by exactly 1 per bubble edge, saturating at 0xFFFF_FFFF (no wrap).
REQ-019 SHALL force A3E=0 and RFWEE=0 whenever a captured RFWED=0, so no false forwarding source is produced.
REQ-020 SHALL pass TnewD through unmodified (no decrement in this stage); TnewE must be 0 for every bubble.
REQ-021 SHALL drive all outputs combinationally from registers only; no D-input-to-E-output combinational path is allowed.

Reset
REQ-022 SHALL, with reset=0 at an edge, clear all E outputs to 0 (PCE=0x0000_3000), ValidE=0 and BubbleCnt=0, overriding hold_e, stall and flush.
REQ-023 SHALL resume normal capture on the first edge at which reset=1; reset asserted mid-hold abandons the hold.

Structure
REQ-024 SHALL take field widths (control widths, PC reset value 0x0000_3000, nop encoding) from the shared pipeline constants package also used by the decoder and the E/M register.
REQ-025 SHALL use one sub-module, pipe_field, a parameterised-width register with synchronous active-low reset and independent en/clr inputs, instantiated per field.

Verification
REQ-026 Reset: reset=0 for 2 edges with stall=flush=hold_e=1 -> all outputs 0, PCE=0x0000_3000, ValidE=0, BubbleCnt=0.
REQ-027 Capture: InstrD=0x3421_0005 (ori), A3D=1, RFWED=1, TnewD=1, PCD=0x3004 -> next cycle InstrE=0x3421_0005, A3E=1, RFWEE=1, TnewE=1, ValidE=1.
REQ-028 Bubble: lw in E, dependent addu in D, stall=1 for 1 edge -> InstrE=0, RFWEE=0, TnewE=0, ValidE=0, BubbleCnt 0->1; stall=0 next edge -> addu captured.
REQ-029 Hold priority: hold_e=1 with stall=1 and flush=1 for 3 edges -> E outputs and BubbleCnt unchanged; hold_e=0 with stall=1 -> one bubble, BubbleCnt +1.
REQ-030 Saturation: force BubbleCnt to 0xFFFF_FFFE, apply 3 bubble edges -> 0xFFFF_FFFF, 0xFFFF_FFFF, 0xFFFF_FFFF.
REQ-031 Write-enable gating: sw captured with A3D=5, RFWED=0 -> A3E=0, RFWEE=0, DmweE=1.
